// File: rtl/mem_port_arbiter_if.sv
// Bus bundle for the shared memory port arbiter:
// CPU and DMA request channels plus the memory macro side.
interface mem_port_arbiter_if #(
  parameter int AW = 32,
  parameter int DW = 32
);
  logic          cpu_req;
  logic          cpu_we;
  logic [AW-1:0] cpu_addr;
  logic [DW-1:0] cpu_wdata;
  logic          cpu_ack;
  logic [DW-1:0] cpu_rdata;
  logic          dma_req;
  logic          dma_we;
  logic [AW-1:0] dma_addr;
  logic [DW-1:0] dma_wdata;
  logic          dma_ack;
  logic [DW-1:0] dma_rdata;
  logic          mem_en;
  logic          mem_we;
  logic [AW-1:0] mem_addr;
  logic [DW-1:0] mem_wdata;
  logic [DW-1:0] mem_rdata;
  logic          busy;
  logic          owner;

  modport slave (
    input  cpu_req, cpu_we, cpu_addr, cpu_wdata,
    input  dma_req, dma_we, dma_addr, dma_wdata,
    input  mem_rdata,
    output cpu_ack, cpu_rdata, dma_ack, dma_rdata,
    output mem_en, mem_we, mem_addr, mem_wdata,
    output busy, owner
  );

  modport master (
    output cpu_req, cpu_we, cpu_addr, cpu_wdata,
    output dma_req, dma_we, dma_addr, dma_wdata,
    output mem_rdata,
    input  cpu_ack, cpu_rdata, dma_ack, dma_rdata,
    input  mem_en, mem_we, mem_addr, mem_wdata,
    input  busy, owner
  );
endinterface

// File: rtl/mem_port_arbiter.sv
// Round-robin arbiter sharing one memory port between
// the CPU control path and the DMA/loader, with wait states.
module mem_port_arbiter #(
  parameter int AW          = 32,
  parameter int DW          = 32,
  parameter int WAIT_CYCLES = 1
) (
  input logic               Clk,
  input logic               Reset,
  mem_port_arbiter_if.slave bus
);

  typedef enum logic [1:0] {
    IDLE,
    ACCESS,
    DONE
  } state_t;

  state_t        state_q, state_d;
  logic [3:0]    cnt_q, cnt_d;
  logic          last_q, last_d;
  logic          en_q, en_d;
  logic          we_q, we_d;
  logic [AW-1:0] addr_q, addr_d;
  logic [DW-1:0] wdata_q, wdata_d;
  logic          cack_q, cack_d;
  logic          dack_q, dack_d;
  logic [DW-1:0] crd_q, crd_d;
  logic [DW-1:0] drd_q, drd_d;
  logic          busy_q, busy_d;
  logic          own_q, own_d;
  logic          pick_dma;

  // State and registered-output update
  always_ff @(posedge Clk) begin
    if (Reset) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      last_q  <= 1'b1;
      en_q    <= 1'b0;
      we_q    <= 1'b0;
      addr_q  <= '0;
      wdata_q <= '0;
      cack_q  <= 1'b0;
      dack_q  <= 1'b0;
      crd_q   <= '0;
      drd_q   <= '0;
      busy_q  <= 1'b0;
      own_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      last_q  <= last_d;
      en_q    <= en_d;
      we_q    <= we_d;
      addr_q  <= addr_d;
      wdata_q <= wdata_d;
      cack_q  <= cack_d;
      dack_q  <= dack_d;
      crd_q   <= crd_d;
      drd_q   <= drd_d;
      busy_q  <= busy_d;
      own_q   <= own_d;
    end
  end

  // DMA wins when alone, or on a tie when CPU went last
  assign pick_dma = bus.dma_req & (~bus.cpu_req | ~last_q);

  // Next-state: grant in IDLE, count waits, pulse ack in DONE
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    last_d  = last_q;
    en_d    = en_q;
    we_d    = we_q;
    addr_d  = addr_q;
    wdata_d = wdata_q;
    cack_d  = 1'b0;
    dack_d  = 1'b0;
    crd_d   = crd_q;
    drd_d   = drd_q;
    own_d   = own_q;
    unique case (state_q)
      IDLE: begin
        en_d = 1'b0;
        we_d = 1'b0;
        if (bus.cpu_req | bus.dma_req) begin
          state_d = ACCESS;
          en_d    = 1'b1;
          cnt_d   = 4'(WAIT_CYCLES);
          own_d   = pick_dma;
          last_d  = pick_dma;
          if (pick_dma) begin
            we_d    = bus.dma_we;
            addr_d  = bus.dma_addr;
            wdata_d = bus.dma_wdata;
          end else begin
            we_d    = bus.cpu_we;
            addr_d  = bus.cpu_addr;
            wdata_d = bus.cpu_wdata;
          end
        end
      end
      ACCESS: begin
        if (cnt_q != 4'd0) begin
          cnt_d = cnt_q - 4'd1;
        end else begin
          if (!we_q) begin
            if (own_q) drd_d = bus.mem_rdata;
            else       crd_d = bus.mem_rdata;
          end
          en_d    = 1'b0;
          we_d    = 1'b0;
          cack_d  = ~own_q;
          dack_d  = own_q;
          state_d = DONE;
        end
      end
      DONE: begin
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
    busy_d = (state_d != IDLE);
  end

  assign bus.mem_en    = en_q;
  assign bus.mem_we    = we_q;
  assign bus.mem_addr  = addr_q;
  assign bus.mem_wdata = wdata_q;
  assign bus.cpu_ack   = cack_q;
  assign bus.dma_ack   = dack_q;
  assign bus.cpu_rdata = crd_q;
  assign bus.dma_rdata = drd_q;
  assign bus.busy      = busy_q;
  assign bus.owner     = own_q;

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Directed bench for mem_port_arbiter: one instance with
// one wait state, one with none, sharing clock and reset.
module tb_mem_port_arbiter;

  logic Clk = 1'b0;
  logic Reset = 1'b1;

  mem_port_arbiter_if #(.AW(32), .DW(32)) b1 ();
  mem_port_arbiter_if #(.AW(32), .DW(32)) b0 ();

  mem_port_arbiter #(
    .AW(32), .DW(32), .WAIT_CYCLES(1)
  ) dut1 (
    .Clk(Clk), .Reset(Reset), .bus(b1)
  );

  mem_port_arbiter #(
    .AW(32), .DW(32), .WAIT_CYCLES(0)
  ) dut0 (
    .Clk(Clk), .Reset(Reset), .bus(b0)
  );

  // memory model: data is a fixed function of the address
  assign b1.mem_rdata = b1.mem_addr ^ 32'hDEADBEFF;
  assign b0.mem_rdata = b0.mem_addr ^ 32'h5A5A0000;

  always #5 Clk = ~Clk;

  int n_run  = 0;
  int n_fail = 0;

  task automatic check(string tag, logic [31:0] got,
                       logic [31:0] exp);
    n_run++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %08h expected %08h",
               tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge Clk);
    #1;
  endtask

  task automatic quiet();
    b1.cpu_req = 0; b1.cpu_we = 0;
    b1.cpu_addr = 0; b1.cpu_wdata = 0;
    b1.dma_req = 0; b1.dma_we = 0;
    b1.dma_addr = 0; b1.dma_wdata = 0;
    b0.cpu_req = 0; b0.cpu_we = 0;
    b0.cpu_addr = 0; b0.cpu_wdata = 0;
    b0.dma_req = 0; b0.dma_we = 0;
    b0.dma_addr = 0; b0.dma_wdata = 0;
  endtask

  int acks;
  int at[4];
  logic own[4];

  initial begin
    quiet();
    Reset = 1;
    tick(); tick();
    check("rst_en", b1.mem_en, 0);
    check("rst_we", b1.mem_we, 0);
    check("rst_busy", b1.busy, 0);
    check("rst_owner", b1.owner, 0);
    check("rst_cack", b1.cpu_ack, 0);
    check("rst_dack", b1.dma_ack, 0);
    check("rst_addr", b1.mem_addr, 0);
    check("rst_crd", b1.cpu_rdata, 0);
    Reset = 0;
    tick();

    // CPU read, one wait state
    b1.cpu_req = 1; b1.cpu_addr = 32'h10;
    tick();
    check("rd_en1", b1.mem_en, 1);
    check("rd_we1", b1.mem_we, 0);
    check("rd_addr1", b1.mem_addr, 32'h10);
    check("rd_busy1", b1.busy, 1);
    check("rd_own1", b1.owner, 0);
    tick();
    check("rd_en2", b1.mem_en, 1);
    check("rd_ack2", b1.cpu_ack, 0);
    tick();
    check("rd_en3", b1.mem_en, 0);
    check("rd_ack3", b1.cpu_ack, 1);
    check("rd_dack3", b1.dma_ack, 0);
    check("rd_data3", b1.cpu_rdata, 32'hDEADBEEF);
    b1.cpu_req = 0;
    tick();
    check("rd_ack4", b1.cpu_ack, 0);
    check("rd_busy4", b1.busy, 0);
    check("rd_hold4", b1.cpu_rdata, 32'hDEADBEEF);

    // tie right after reset, then sustained contention
    Reset = 1; tick(); Reset = 0;
    b1.cpu_req = 1; b1.cpu_addr = 32'h20;
    b1.dma_req = 1; b1.dma_addr = 32'h30;
    acks = 0;
    for (int i = 1; i <= 15; i++) begin
      tick();
      check("rr_excl", b1.cpu_ack & b1.dma_ack, 0);
      if (b1.cpu_ack | b1.dma_ack) begin
        if (acks < 4) begin
          at[acks]  = i;
          own[acks] = b1.dma_ack;
        end
        check("rr_owner", b1.owner, b1.dma_ack);
        acks++;
      end
    end
    b1.cpu_req = 0; b1.dma_req = 0;
    check("rr_count", acks, 4);
    for (int k = 0; k < 4; k++) begin
      check("rr_time", at[k], 3 + 4 * k);
      check("rr_seq", own[k], k % 2);
    end
    tick(); tick();
    check("rr_idle", b1.busy, 0);
    check("rr_crd", b1.cpu_rdata, 32'hDEADBEDF);
    check("rr_drd", b1.dma_rdata, 32'hDEADBECF);

    // no-wait DMA read then DMA write
    b0.dma_req = 1; b0.dma_addr = 32'h40;
    tick();
    check("d_rd_en", b0.mem_en, 1);
    check("d_rd_own", b0.owner, 1);
    tick();
    check("d_rd_ack", b0.dma_ack, 1);
    check("d_rd_cack", b0.cpu_ack, 0);
    check("d_rd_data", b0.dma_rdata, 32'h5A5A0040);
    b0.dma_req = 0;
    tick();
    b0.dma_req = 1; b0.dma_we = 1;
    b0.dma_addr = 32'h100; b0.dma_wdata = 32'h12345678;
    tick();
    check("d_wr_en", b0.mem_en, 1);
    check("d_wr_we", b0.mem_we, 1);
    check("d_wr_addr", b0.mem_addr, 32'h100);
    check("d_wr_data", b0.mem_wdata, 32'h12345678);
    tick();
    check("d_wr_we2", b0.mem_we, 0);
    check("d_wr_en2", b0.mem_en, 0);
    check("d_wr_ack", b0.dma_ack, 1);
    check("d_wr_hold", b0.dma_rdata, 32'h5A5A0040);
    b0.dma_req = 0; b0.dma_we = 0;
    tick();
    check("d_wr_ack3", b0.dma_ack, 0);

    // reset during the second ACCESS cycle of a CPU read
    b1.cpu_req = 1; b1.cpu_addr = 32'h50;
    tick();
    tick();
    check("ra_en", b1.mem_en, 1);
    Reset = 1;
    tick();
    check("ra_en0", b1.mem_en, 0);
    check("ra_we0", b1.mem_we, 0);
    check("ra_busy0", b1.busy, 0);
    check("ra_ack0", b1.cpu_ack, 0);
    Reset = 0;
    b1.dma_req = 1; b1.dma_addr = 32'h58;
    tick();
    check("ra_ack1", b1.cpu_ack, 0);
    check("ra_own", b1.owner, 0);
    check("ra_addr", b1.mem_addr, 32'h50);
    b1.cpu_req = 0; b1.dma_req = 0;
    tick(); tick();
    check("ra_ack3", b1.cpu_ack, 1);
    tick(); tick();
    check("ra_idle", b1.busy, 0);

    // request dropped after grant, address changed
    b1.cpu_req = 1; b1.cpu_addr = 32'h60;
    tick();
    check("dr_addr1", b1.mem_addr, 32'h60);
    b1.cpu_req = 0; b1.cpu_addr = 32'h70;
    b1.cpu_we = 1; b1.cpu_wdata = 32'hFFFF0000;
    tick();
    check("dr_en2", b1.mem_en, 1);
    check("dr_addr2", b1.mem_addr, 32'h60);
    check("dr_we2", b1.mem_we, 0);
    tick();
    check("dr_ack3", b1.cpu_ack, 1);
    check("dr_data3", b1.cpu_rdata, 32'hDEADBE9F);
    tick();
    check("dr_ack4", b1.cpu_ack, 0);
    tick();
    check("dr_busy5", b1.busy, 0);

    $display("[TB] %0d tests run, %0d failed", n_run, n_fail);
    $finish;
  end

endmodule
